// File: rtl/lw_scoreboard_hazard_if.sv
// ID-stage hazard scoreboard bus: decoded instruction fields in, stall/status out.
interface lw_scoreboard_hazard_if #(
    parameter int AW = 5
);
    logic          Valid;
    logic [AW-1:0] Rs;
    logic [AW-1:0] Rt;
    logic          UseRs;
    logic          UseRt;
    logic          Early;
    logic          WB;
    logic          MR;
    logic [AW-1:0] Dst;
    logic          Hold;
    logic          Flush;
    logic          Blk;
    logic          Pending;
    logic [31:0]   StallCnt;

    modport master (
        output Valid, Rs, Rt, UseRs, UseRt, Early, WB, MR, Dst, Hold, Flush,
        input  Blk, Pending, StallCnt
    );

    modport slave (
        input  Valid, Rs, Rt, UseRs, UseRt, Early, WB, MR, Dst, Hold, Flush,
        output Blk, Pending, StallCnt
    );
endinterface

// File: rtl/lw_scoreboard_hazard.sv
// Countdown scoreboard hazard unit: stalls ID until every source can be forwarded.
// Optional stall statistic counter enabled by macro HAZARD_STATS_EN.
module lw_scoreboard_hazard #(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    parameter int LATE_SLACK = 1,
    parameter int CW         = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    lw_scoreboard_hazard_if.slave     sb_io
);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t        ALU_V   = cnt_t'(ALU_LAT);
    localparam cnt_t        LOAD_V  = cnt_t'(LOAD_LAT);
    localparam logic [31:0] SLACK_V = 32'(LATE_SLACK);

    cnt_t cnt_q [NREG];
    cnt_t cnt_d [NREG];

    logic rs_ready_s;
    logic rt_ready_s;
    logic blk_s;
    logic issue_s;
    logic pending_s;

    // Out-of-range indices read as an untracked (always ready) register.
    function automatic cnt_t get_cnt(input logic [AW-1:0] idx, input cnt_t arr [NREG]);
        cnt_t val;
        if (32'(idx) < 32'(NREG)) begin
            val = arr[idx];
        end else begin
            val = {CW{1'b0}};
        end
        return val;
    endfunction

    function automatic logic src_ready(input cnt_t c, input logic early);
        logic rdy;
        if (early) begin
            rdy = (c == {CW{1'b0}});
        end else begin
            rdy = (32'(c) <= SLACK_V);
        end
        return rdy;
    endfunction

    // Per-source readiness, stall request and issue qualification
    always_comb begin
        rs_ready_s = 1'b1;
        rt_ready_s = 1'b1;
        if (sb_io.UseRs && (sb_io.Rs != {AW{1'b0}})) begin
            rs_ready_s = src_ready(get_cnt(sb_io.Rs, cnt_q), sb_io.Early);
        end else begin
            rs_ready_s = 1'b1;
        end
        if (sb_io.UseRt && (sb_io.Rt != {AW{1'b0}})) begin
            rt_ready_s = src_ready(get_cnt(sb_io.Rt, cnt_q), sb_io.Early);
        end else begin
            rt_ready_s = 1'b1;
        end
        blk_s   = sb_io.Valid & ~sb_io.Flush & ~rst & ~(rs_ready_s & rt_ready_s);
        issue_s = sb_io.Valid & ~blk_s & ~sb_io.Hold & ~sb_io.Flush;
    end

    // Counter next state: a new writer's load wins over the decrement of an older one
    always_comb begin
        cnt_d[0] = {CW{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            if (issue_s && sb_io.WB && (sb_io.Dst == AW'(i))) begin
                cnt_d[i] = sb_io.MR ? LOAD_V : ALU_V;
            end else if (!sb_io.Hold && (cnt_q[i] != {CW{1'b0}})) begin
                cnt_d[i] = cnt_q[i] - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Any in-flight result
    always_comb begin
        pending_s = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (cnt_q[i] != {CW{1'b0}}) begin
                pending_s = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
    end

    assign sb_io.Blk     = blk_s;
    assign sb_io.Pending = pending_s & ~rst;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Saturating count of non-frozen stall cycles
    always_comb begin
        if (blk_s && !sb_io.Hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall statistic register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb_io.StallCnt = stall_cnt_q;
`else
    assign sb_io.StallCnt = 32'd0;
`endif
endmodule

// File: tb/tb_lw_scoreboard_hazard.sv
// Directed bench for lw_scoreboard_hazard with default latencies (ALU 1, LOAD 2, slack 1).
module tb_lw_scoreboard_hazard;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lw_scoreboard_hazard_if #(.AW(5)) sb ();

    lw_scoreboard_hazard dut (
        .clk   (clk),
        .rst   (rst),
        .sb_io (sb)
    );

    task automatic ins(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit early,
                       input bit wb, input bit mr, input logic [4:0] dst);
        sb.Valid = v;   sb.Rs = rs;   sb.Rt = rt;
        sb.UseRs = urs; sb.UseRt = urt; sb.Early = early;
        sb.WB = wb;     sb.MR = mr;   sb.Dst = dst;
    endtask

    task automatic idle();
        ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
        #1;
        n_cmp++;
        if (sb.Pending !== 1'b0) begin
            n_err++; $display("FAIL drain_pending got=%b want=0", sb.Pending);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sb.Hold = 1'b0; sb.Flush = 1'b0;
        ins(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1);
        tick();
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL reset_blk got=%b want=0", sb.Blk); end
        n_cmp++;
        if (sb.Pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%b want=0", sb.Pending); end
        n_cmp++;
        if (sb.StallCnt !== 32'd0) begin n_err++; $display("FAIL reset_stallcnt got=%0d want=0", sb.StallCnt); end
        idle();
        rst = 1'b0;
        tick();
    endtask

    // producer -> consumer pair, expecting a given number of bubbles
    task automatic run_pair(input bit mr, input logic [4:0] dst, input bit early, input int bubbles);
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, mr, dst);
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL pair_prod_blk got=%b want=0", sb.Blk); end
        tick();
        ins(1'b1, dst, 5'd0, 1'b1, 1'b1, early, 1'b0, 1'b0, 5'd0);
        for (int b = 0; b < bubbles; b++) begin
            #1;
            n_cmp++;
            if (sb.Blk !== 1'b1) begin
                n_err++; $display("FAIL pair_stall%0d mr=%0d early=%0d got=%b want=1", b, mr, early, sb.Blk);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin
            n_err++; $display("FAIL pair_release mr=%0d early=%0d got=%b want=0", mr, early, sb.Blk);
        end
        tick();
        drain();
    endtask

    task automatic test_load_alu();
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1);
        tick();
        ins(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2);
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b1) begin n_err++; $display("FAIL ldalu_stall got=%b want=1", sb.Blk); end
        n_cmp++;
        if (sb.Pending !== 1'b1) begin n_err++; $display("FAIL ldalu_pend2 got=%b want=1", sb.Pending); end
        tick();
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL ldalu_issue got=%b want=0", sb.Blk); end
        n_cmp++;
        if (sb.Pending !== 1'b1) begin n_err++; $display("FAIL ldalu_pend1 got=%b want=1", sb.Pending); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (sb.Pending !== 1'b1) begin n_err++; $display("FAIL ldalu_addpend got=%b want=1", sb.Pending); end
        tick();
        #1;
        n_cmp++;
        if (sb.Pending !== 1'b0) begin n_err++; $display("FAIL ldalu_empty got=%b want=0", sb.Pending); end
    endtask

    task automatic test_early_branch();
        run_pair(1'b1, 5'd4, 1'b1, 2);
        run_pair(1'b0, 5'd4, 1'b1, 1);
        run_pair(1'b0, 5'd5, 1'b0, 0);
        run_pair(1'b1, 5'd6, 1'b0, 1);
    endtask

    task automatic test_hold();
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
        tick();
        ins(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
        sb.Hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (sb.Blk !== 1'b1) begin n_err++; $display("FAIL hold_blk%0d got=%b want=1", c, sb.Blk); end
            tick();
        end
        sb.Hold = 1'b0;
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b1) begin n_err++; $display("FAIL hold_after got=%b want=1", sb.Blk); end
        tick();
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL hold_release got=%b want=0", sb.Blk); end
        tick();
        drain();
    endtask

    task automatic test_reg0();
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        tick();
        ins(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL reg0_blk got=%b want=0", sb.Blk); end
        n_cmp++;
        if (sb.Pending !== 1'b0) begin n_err++; $display("FAIL reg0_pending got=%b want=0", sb.Pending); end
        tick();
        idle();
    endtask

    task automatic test_reload();
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
        tick();
        ins(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL reload_add got=%b want=0", sb.Blk); end
        tick();
        ins(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b1) begin n_err++; $display("FAIL reload_stall got=%b want=1", sb.Blk); end
        tick();
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL reload_release got=%b want=0", sb.Blk); end
        tick();
        drain();
    endtask

    task automatic test_flush();
        sb.Flush = 1'b1;
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12);
        tick();
        sb.Flush = 1'b0;
        idle();
        #1;
        n_cmp++;
        if (sb.Pending !== 1'b0) begin n_err++; $display("FAIL flush_noupd got=%b want=0", sb.Pending); end
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd13);
        tick();
        ins(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        sb.Flush = 1'b1;
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL flush_blk got=%b want=0", sb.Blk); end
        tick();
        sb.Flush = 1'b0;
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b1) begin n_err++; $display("FAIL flush_keepcount got=%b want=1", sb.Blk); end
        tick();
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL flush_release got=%b want=0", sb.Blk); end
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11);
        tick();
        ins(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got=%b want=1", sb.Blk); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL rstmid_blk got=%b want=0", sb.Blk); end
        n_cmp++;
        if (sb.Pending !== 1'b0) begin n_err++; $display("FAIL rstmid_pending got=%b want=0", sb.Pending); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (sb.Blk !== 1'b0) begin n_err++; $display("FAIL rstmid_cleared got=%b want=0", sb.Blk); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_stats();
        logic [31:0] want;
`ifdef HAZARD_STATS_EN
        want = 32'd10;
`else
        want = 32'd0;
`endif
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            run_pair(1'b1, 5'd4, 1'b1, 2);
        end
        n_cmp++;
        if (sb.StallCnt !== want) begin
            n_err++; $display("FAIL stats_count got=%0d want=%0d", sb.StallCnt, want);
        end
    endtask

    initial begin
        test_reset();
        test_load_alu();
        test_early_branch();
        test_hold();
        test_reg0();
        test_reload();
        test_flush();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
